// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and size helper for the data-memory access controller.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int unsigned MEM_BYTES_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RESP
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Right-justified load data extension: zero- or sign-extends byte and half-word reads.
module load_extend
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] data,
    output logic [31:0] ext
);

    always_comb begin
        ext = data;
        case (size)
            SZ_BYTE: ext = {{24{sign & data[7]}}, data[7:0]};
            SZ_HALF: ext = {{16{sign & data[15]}}, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller sequencing the data RAM as SETUP (controls) -> STROBE (enable) -> RESP.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    logic        hold_write;
    logic        hold_signed;
    logic [1:0]  hold_size;
    logic        req_error;
    logic [32:0] last_byte;
    logic [31:0] wdata_masked;
    logic [31:0] load_data;

    // 33-bit sum so addresses near 2^32 cannot wrap into range
    always_comb begin
        last_byte = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
        req_error = 1'b0;
        if (req_size == SZ_ILL)
            req_error = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            req_error = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_error = 1'b1;
        if (last_byte >= 33'(MEM_BYTES))
            req_error = 1'b1;

        wdata_masked = req_wdata;
        case (req_size)
            SZ_BYTE: wdata_masked = {24'b0, req_wdata[7:0]};
            SZ_HALF: wdata_masked = {16'b0, req_wdata[15:0]};
            default: wdata_masked = req_wdata;
        endcase
    end

    load_extend u_load_extend (
        .size (hold_size),
        .sign (hold_signed),
        .data (mem_rdata),
        .ext  (load_data)
    );

    // mem_* controls only change on a legal accept, so they are stable across the enable pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_rdata   <= '0;
            mem_enable  <= 1'b0;
            mem_rw      <= 1'b0;
            mem_size    <= SZ_BYTE;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hold_write  <= 1'b0;
            hold_signed <= 1'b0;
            hold_size   <= SZ_BYTE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        hold_write  <= req_write;
                        hold_signed <= req_signed;
                        hold_size   <= req_size;
                        req_ready   <= 1'b0;
                        rsp_rdata   <= '0;
                        if (req_error) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end else begin
                            state     <= SETUP;
                            rsp_error <= 1'b0;
                            mem_rw    <= req_write;
                            mem_size  <= req_size;
                            mem_addr  <= req_addr;
                            mem_wdata <= wdata_masked;
                        end
                    end
                end
                SETUP: begin
                    state      <= STROBE;
                    mem_enable <= 1'b1;
                end
                STROBE: begin
                    state      <= RESP;
                    mem_enable <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_rdata  <= hold_write ? '0 : load_data;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a byte-addressed little-endian RAM model.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = SZ_BYTE;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] mwd;
    } req_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails = 0;
    int   en_count = 0;
    int   glitch = 0;
    int   double_en = 0;
    logic [66:0] prev_ctrl = '0;
    logic        prev_en = 1'b0;
    logic [7:0]  ram [0:255];

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = {ram[8'(mem_addr[7:0] + 8'd3)], ram[8'(mem_addr[7:0] + 8'd2)],
                        ram[8'(mem_addr[7:0] + 8'd1)], ram[mem_addr[7:0]]};

    always @(posedge clk) begin
        if (mem_enable && mem_rw) begin
            ram[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_size != SZ_BYTE)
                ram[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
            if (mem_size == SZ_WORD) begin
                ram[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
                ram[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_enable) begin
            en_count <= en_count + 1;
            if ({mem_rw, mem_size, mem_addr, mem_wdata} !== prev_ctrl)
                glitch <= glitch + 1;
            if (prev_en)
                double_en <= double_en + 1;
        end
        prev_ctrl <= {mem_rw, mem_size, mem_addr, mem_wdata};
        prev_en   <= mem_enable;
    end

    task automatic send_req(input req_t r, output logic ok);
        exp_t e;
        int   n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok)
            return;
        req_write  = r.w;
        req_size   = r.sz;
        req_signed = r.sg;
        req_addr   = r.addr;
        req_wdata  = r.wdata;
        req_valid  = 1'b1;
        e.rdata = r.rdata;
        e.err   = r.err;
        e.lat   = r.err ? 1 : 3;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        n_checks++;
        if ({rsp_valid, rsp_error, mem_enable} !== 3'b000) begin
            n_fails++;
            $display("FAIL reset_flags got=%b exp=000", {rsp_valid, rsp_error, mem_enable});
        end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_rdata got=%h exp=00000000", rsp_rdata);
        end
        n_checks++;
        if ({mem_rw, mem_size, mem_addr, mem_wdata} !== 67'h0) begin
            n_fails++;
            $display("FAIL reset_mem_ctrl got=%h exp=0", {mem_rw, mem_size, mem_addr, mem_wdata});
        end
        reset = 1'b0;
    endtask

    task automatic test_word_store_load;
        req_t r[2];
        r[0] = '{1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF};
        r[1] = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
        foreach (r[i]) begin
            logic ok;
            int   lat, e0;
            exp_t e;
            e0 = en_count;
            send_req(r[i], ok);
            n_checks++;
            if (!ok) begin
                n_fails++;
                $display("FAIL wsl_accept[%0d] req_ready stuck low", i);
                continue;
            end
            wait_rsp(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat !== e.lat) begin
                n_fails++;
                $display("FAIL wsl_latency[%0d] got=%0d exp=%0d", i, lat, e.lat);
            end
            n_checks++;
            if ({rsp_error, rsp_rdata} !== {e.err, e.rdata}) begin
                n_fails++;
                $display("FAIL wsl_rsp[%0d] got err=%b data=%h exp err=%b data=%h", i, rsp_error, rsp_rdata, e.err, e.rdata);
            end
            n_checks++;
            if (en_count - e0 !== 1) begin
                n_fails++;
                $display("FAIL wsl_enable_pulses[%0d] got=%0d exp=1", i, en_count - e0);
            end
            if (r[i].w) begin
                n_checks++;
                if (mem_wdata !== r[i].mwd) begin
                    n_fails++;
                    $display("FAIL wsl_mem_wdata[%0d] got=%h exp=%h", i, mem_wdata, r[i].mwd);
                end
            end
            take_rsp();
        end
    endtask

    task automatic test_byte_half;
        req_t r[7];
        r[0] = '{1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hAABBCC80, 32'h0,        1'b0, 32'h00000080};
        r[1] = '{1'b1, SZ_HALF, 1'b0, 32'h22, 32'h12349234, 32'h0,        1'b0, 32'h00009234};
        r[2] = '{1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0, 32'h0};
        r[3] = '{1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0,        32'h00000080, 1'b0, 32'h0};
        r[4] = '{1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0,        32'hFFFF9234, 1'b0, 32'h0};
        r[5] = '{1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0,        32'h00009234, 1'b0, 32'h0};
        r[6] = '{1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0,        32'h00000034, 1'b0, 32'h0};
        foreach (r[i]) begin
            logic ok;
            int   lat;
            exp_t e;
            send_req(r[i], ok);
            n_checks++;
            if (!ok) begin
                n_fails++;
                $display("FAIL bh_accept[%0d] req_ready stuck low", i);
                continue;
            end
            wait_rsp(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat !== e.lat) begin
                n_fails++;
                $display("FAIL bh_latency[%0d] got=%0d exp=%0d", i, lat, e.lat);
            end
            n_checks++;
            if ({rsp_error, rsp_rdata} !== {e.err, e.rdata}) begin
                n_fails++;
                $display("FAIL bh_rsp[%0d] got err=%b data=%h exp err=%b data=%h", i, rsp_error, rsp_rdata, e.err, e.rdata);
            end
            if (r[i].w) begin
                n_checks++;
                if (mem_wdata !== r[i].mwd) begin
                    n_fails++;
                    $display("FAIL bh_mem_wdata[%0d] got=%h exp=%h", i, mem_wdata, r[i].mwd);
                end
            end
            take_rsp();
        end
    endtask

    task automatic test_errors;
        req_t r[9];
        r[0] = '{1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0,        32'h0,        1'b1, 32'h0};
        r[1] = '{1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1, 32'h0};
        r[2] = '{1'b0, SZ_WORD, 1'b0, 32'hFD, 32'h0,        32'h0,        1'b1, 32'h0};
        r[3] = '{1'b1, SZ_ILL,  1'b0, 32'h00, 32'h55555555, 32'h0,        1'b1, 32'h0};
        r[4] = '{1'b1, SZ_WORD, 1'b0, 32'hFC, 32'h04030201, 32'h0,        1'b0, 32'h04030201};
        r[5] = '{1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0,        32'h04030201, 1'b0, 32'h0};
        r[6] = '{1'b0, SZ_BYTE, 1'b0, 32'hFF, 32'h0,        32'h00000004, 1'b0, 32'h0};
        r[7] = '{1'b0, SZ_HALF, 1'b0, 32'hFF, 32'h0,        32'h0,        1'b1, 32'h0};
        r[8] = '{1'b0, SZ_HALF, 1'b0, 32'hFE, 32'h0,        32'h00000403, 1'b0, 32'h0};
        foreach (r[i]) begin
            logic        ok;
            int          lat, e0;
            logic [66:0] ctrl0;
            exp_t        e;
            e0 = en_count;
            ctrl0 = {mem_rw, mem_size, mem_addr, mem_wdata};
            send_req(r[i], ok);
            n_checks++;
            if (!ok) begin
                n_fails++;
                $display("FAIL err_accept[%0d] req_ready stuck low", i);
                continue;
            end
            wait_rsp(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat !== e.lat) begin
                n_fails++;
                $display("FAIL err_latency[%0d] got=%0d exp=%0d", i, lat, e.lat);
            end
            n_checks++;
            if ({rsp_error, rsp_rdata} !== {e.err, e.rdata}) begin
                n_fails++;
                $display("FAIL err_rsp[%0d] got err=%b data=%h exp err=%b data=%h", i, rsp_error, rsp_rdata, e.err, e.rdata);
            end
            n_checks++;
            if (en_count - e0 !== (e.err ? 0 : 1)) begin
                n_fails++;
                $display("FAIL err_enable_pulses[%0d] got=%0d exp=%0d", i, en_count - e0, e.err ? 0 : 1);
            end
            if (e.err) begin
                n_checks++;
                if ({mem_rw, mem_size, mem_addr, mem_wdata} !== ctrl0) begin
                    n_fails++;
                    $display("FAIL err_mem_hold[%0d] got=%h exp=%h", i, {mem_rw, mem_size, mem_addr, mem_wdata}, ctrl0);
                end
            end
            take_rsp();
        end
    endtask

    task automatic test_backpressure;
        req_t r;
        logic ok;
        int   lat;
        exp_t e;
        r = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0};
        send_req(r, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL bp_accept req_ready stuck low");
            return;
        end
        wait_rsp(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat) begin
            n_fails++;
            $display("FAIL bp_latency got=%0d exp=%0d", lat, e.lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, req_ready, rsp_error, rsp_rdata} !== {1'b1, 1'b0, e.err, e.rdata}) begin
                n_fails++;
                $display("FAIL bp_hold[%0d] got valid=%b ready=%b err=%b data=%h exp valid=1 ready=0 err=%b data=%h",
                         c, rsp_valid, req_ready, rsp_error, rsp_rdata, e.err, e.rdata);
            end
        end
        take_rsp();
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        req_t r[2];
        r[0] = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0};
        r[1] = '{1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 32'h0};
        foreach (r[i]) begin
            logic ok;
            int   lat;
            exp_t e;
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fails++;
                $display("FAIL b2b_first_idle_ready[%0d] got=%b exp=1", i, req_ready);
            end
            send_req(r[i], ok);
            n_checks++;
            if (!ok) begin
                n_fails++;
                $display("FAIL b2b_accept[%0d] req_ready stuck low", i);
                continue;
            end
            wait_rsp(lat);
            e = sb.pop_front();
            n_checks++;
            if (lat !== e.lat || {rsp_error, rsp_rdata} !== {e.err, e.rdata}) begin
                n_fails++;
                $display("FAIL b2b_rsp[%0d] got lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h",
                         i, lat, rsp_error, rsp_rdata, e.lat, e.err, e.rdata);
            end
            take_rsp();
        end
        n_checks++;
        if (glitch !== 0 || double_en !== 0) begin
            n_fails++;
            $display("FAIL enable_shape got glitch=%0d double=%0d exp 0 0", glitch, double_en);
        end
    endtask

    task automatic test_reset_mid;
        int e0;
        req_write  = 1'b0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_enable !== 1'b1) begin
            n_fails++;
            $display("FAIL rm_in_strobe mem_enable got=%b exp=1", mem_enable);
        end
        reset     = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_enable, req_ready, rsp_valid} !== 3'b010) begin
            n_fails++;
            $display("FAIL rm_after_reset got en=%b ready=%b valid=%b exp en=0 ready=1 valid=0", mem_enable, req_ready, rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, mem_addr, mem_size} !== {1'b1, 32'h0, SZ_BYTE}) begin
            n_fails++;
            $display("FAIL rm_reset_over_valid got ready=%b addr=%h size=%b exp ready=1 addr=00000000 size=00", req_ready, mem_addr, mem_size);
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        e0 = en_count;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || en_count !== e0) begin
                n_fails++;
                $display("FAIL rm_no_response[%0d] got valid=%b pulses=%0d exp valid=0 pulses=0", c, rsp_valid, en_count - e0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
